test_monitor: RTL and testbench
===============================

# test_monitor

Synthesizable riscv-tests completion monitor that replaces fixed-tick, single-register pass/fail checks in simulation benches and FPGA bring-up. It sits beside one or more cores and snoops each core's register write-back and `ecall` retirement. Per channel it keeps a shadow of `gp` (x3) and produces a sticky PASS/FAIL/TIMEOUT verdict with the failing test number. A global watchdog bounds run time.

## Interface
Parameters:
- `NCH`, 1: number of monitored cores (channels).
- `XLEN`, 32: register/data width.
- `TIMEOUT`, 5000: cycles after reset release before an unfinished channel is declared TIMEOUT.
- `CNT_W`, 32: width of the cycle counter. `TIMEOUT` must fit in `CNT_W`.
- `TOHOST_ADDR`, 32'h0000_1000: tohost word address. Used only with `TEST_MONITOR_TOHOST_EN`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low. 0 resets the block.
- `wb_valid`, in, NCH: per-channel register write-back strobe.
- `wb_rd`, in, NCH*5: destination register index, flattened; channel c is at [5c+4:5c].
- `wb_data`, in, NCH*XLEN: write-back data, flattened.
- `ecall_valid`, in, NCH: an `ecall` instruction retired this cycle.
- `st_valid`, in, NCH: store strobe. Only with the macro defined.
- `st_addr`, in, NCH*XLEN: store address. Only with the macro defined.
- `st_data`, in, NCH*XLEN: store data. Only with the macro defined.
- `done`, out, NCH: channel has a verdict.
- `pass`, out, NCH: the verdict is PASS.
- `timeout`, out, NCH: the verdict is TIMEOUT.
- `fail_num`, out, NCH*XLEN: failing test number, `gp >> 1`. 0 unless the verdict is FAIL.
- `verdict_cycle`, out, NCH*CNT_W: value of the cycle counter when the verdict was latched.
- `all_done`, out, 1: every channel has a verdict.
- `cycle`, out, CNT_W: free-running cycle count since reset release.

## Operation
- Each channel has the states RUN, PASS, FAIL and TIMEOUT. Reset enters RUN. PASS, FAIL and TIMEOUT are terminal until reset.
- Shadow `gp` register: reset value 0. It loads `wb_data` when `wb_valid && wb_rd==3`. Writes to x0 and other registers are ignored.
- Effective gp: if `gp` is written in the same cycle as `ecall_valid`, the new value is used (bypass).
- RUN with `ecall_valid`:
  - effective gp == 1 → PASS.
  - otherwise → FAIL, with `fail_num = gp >> 1` (logical shift).
- RUN with no `ecall` and `cycle == TIMEOUT-1` → TIMEOUT.
- An `ecall` in the same cycle as the timeout condition: `ecall` wins.
- In a terminal state, all further snoop inputs are ignored and the outputs are frozen.
- `cycle` increments every cycle and saturates at all-ones; it does not wrap.
- `all_done` is the AND of `done` across all channels.

## Timing
- Every output is registered. The verdict appears one cycle after the triggering edge.
- Reset values: all outputs 0. Channel state RUN.
- `cycle` is 0 in the first cycle after `rst` rises. It increments on each following edge.
- `verdict_cycle` captures the `cycle` value of the triggering cycle, not the following one.
- Reset asserted mid-run clears every channel immediately and asynchronously, including terminal channels.
- `all_done` rises in the same cycle as the last channel's `done`.

## Configuration
- `TEST_MONITOR_TOHOST_EN` defined:
  - The `st_*` ports exist.
  - A store with `st_addr == TOHOST_ADDR` and `st_data != 0` acts as a verdict trigger. `st_data == 1` → PASS; any other value → FAIL with `fail_num = st_data >> 1`.
  - This trigger is ORed with the `ecall` trigger. If both occur in one cycle, the tohost value decides.
- Not defined:
  - The `st_*` ports are absent.
  - Only the `ecall`/gp trigger is used.

## Structure
- Shared package `test_monitor_pkg`:
  - State enum: RUN, PASS, FAIL, TIMEOUT.
  - `GP_IDX = 5'd3`.
  - `PASS_CODE = 1`.
- Sub-module `test_monitor_chan`: holds one channel's shadow gp, state machine and verdict registers.
- The top module generates `NCH` instances of `test_monitor_chan` and owns the shared cycle counter, watchdog compare and `all_done`.

## Test plan
- Write gp=1 at cycle 10, then `ecall` at cycle 20 → next cycle `done=1`, `pass=1`, `fail_num=0`, `verdict_cycle=20`.
- Write gp=7, then `ecall` → `done=1`, `pass=0`, `fail_num=3`. Later writes of gp=1 plus another `ecall` leave all outputs unchanged.
- gp=5 held, with a write of gp=1 and `ecall` in the same cycle → PASS (bypass).
- NCH=2, TIMEOUT=100: ch0 passes at cycle 30, ch1 stays idle →
  - ch1 `timeout=1`, `verdict_cycle=99`.
  - `all_done` rises the cycle after cycle 99.
- `ecall` with gp=1 exactly at cycle TIMEOUT-1 → PASS, not TIMEOUT. Drop `rst` mid-run → all outputs 0 asynchronously, and `cycle` restarts at 0 after release.
- With `TEST_MONITOR_TOHOST_EN`:
  - Store 0x15 to TOHOST_ADDR → FAIL, `fail_num=10`.
  - Store 0 to TOHOST_ADDR → no verdict.
  - Store 1 to another address → no verdict.

Source files
------------

// File: rtl/test_monitor_pkg.sv
// Shared definitions for the riscv-tests completion monitor.
// Holds the per-channel state encoding and the ABI constants the
// monitor decodes (gp register index and the pass code).
package test_monitor_pkg;

  // Width of a register index on the write-back bus.
  localparam int unsigned REG_IDX_W = 5;

  // x3 (gp) carries the riscv-tests result code.
  localparam logic [REG_IDX_W-1:0] GP_IDX = 5'd3;

  // Result code meaning the test passed.
  localparam int unsigned PASS_CODE = 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } chan_state_e;

endpackage

// File: rtl/test_monitor_chan.sv
// One monitor channel: shadow gp, verdict state machine and sticky
// verdict registers.
// Optional feature macro: TEST_MONITOR_TOHOST_EN (adds the tohost store
// trigger and the st_* ports).
// Ports:
//   clk, rst            clock, async active-low reset
//   wb_valid/rd/data    register write-back snoop
//   ecall_valid         ecall retired this cycle
//   st_valid/addr/data  store snoop (macro only)
//   timeout_hit         shared watchdog compare, high in cycle TIMEOUT-1
//   cycle               shared cycle counter value
//   done_c              next-cycle value of done (combinational)
//   done/pass/timeout   registered verdict flags
//   fail_num            gp >> 1 on FAIL, else 0
//   verdict_cycle       cycle value of the triggering cycle
module test_monitor_chan
  import test_monitor_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
`ifdef TEST_MONITOR_TOHOST_EN
  ,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_1000)
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 ecall_valid,
`ifdef TEST_MONITOR_TOHOST_EN
  input  logic                 st_valid,
  input  logic [XLEN-1:0]      st_addr,
  input  logic [XLEN-1:0]      st_data,
`endif
  input  logic                 timeout_hit,
  input  logic [CNT_W-1:0]     cycle,
  output logic                 done_c,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [XLEN-1:0]      fail_num,
  output logic [CNT_W-1:0]     verdict_cycle
);

  chan_state_e       state_q, state_d;
  logic [XLEN-1:0]   gp_q, gp_d;
  logic              done_d, pass_d, timeout_d;
  logic [XLEN-1:0]   fail_num_d;
  logic [CNT_W-1:0]  verdict_cycle_d;
  logic              gp_wr;
  logic              trig;
  logic [XLEN-1:0]   code;
`ifdef TEST_MONITOR_TOHOST_EN
  logic              st_hit;
`endif

  // State and verdict registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_RUN;
      gp_q          <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      fail_num      <= '0;
      verdict_cycle <= '0;
    end else begin
      state_q       <= state_d;
      gp_q          <= gp_d;
      done          <= done_d;
      pass          <= pass_d;
      timeout       <= timeout_d;
      fail_num      <= fail_num_d;
      verdict_cycle <= verdict_cycle_d;
    end
  end

  // Next state: trigger decode, gp bypass and verdict capture.
  always_comb begin
    state_d         = state_q;
    gp_d            = gp_q;
    done_d          = done;
    pass_d          = pass;
    timeout_d       = timeout;
    fail_num_d      = fail_num;
    verdict_cycle_d = verdict_cycle;

    gp_wr = wb_valid && (wb_rd == GP_IDX);
    // A gp write in the ecall cycle is the value the test meant to report.
    code  = gp_wr ? wb_data : gp_q;
    trig  = ecall_valid;
`ifdef TEST_MONITOR_TOHOST_EN
    st_hit = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0);
    // tohost overrides gp when both fire together.
    if (st_hit) begin
      code = st_data;
    end
    trig = trig || st_hit;
`endif

    case (state_q)
      ST_RUN: begin
        if (gp_wr) begin
          gp_d = wb_data;
        end
        if (trig) begin
          done_d          = 1'b1;
          verdict_cycle_d = cycle;
          if (code == XLEN'(PASS_CODE)) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d    = ST_FAIL;
            fail_num_d = code >> 1;
          end
        end else if (timeout_hit) begin
          state_d         = ST_TIMEOUT;
          done_d          = 1'b1;
          timeout_d       = 1'b1;
          verdict_cycle_d = cycle;
        end
      end
      // Terminal states hold everything until reset.
      default: begin
      end
    endcase

    done_c = done_d;
  end

endmodule

// File: rtl/test_monitor.sv
// riscv-tests completion monitor: snoops each core's write-back and ecall
// retirement and reports a sticky PASS/FAIL/TIMEOUT verdict per channel.
// Optional feature macro: TEST_MONITOR_TOHOST_EN (tohost store trigger,
// adds st_valid/st_addr/st_data).
// Ports:
//   clk, rst           clock, async active-low reset
//   wb_valid/rd/data   per-channel write-back snoop (flattened)
//   ecall_valid        per-channel ecall retirement
//   st_*               per-channel store snoop (macro only)
//   done/pass/timeout  per-channel verdict flags
//   fail_num           per-channel failing test number
//   verdict_cycle      per-channel cycle of the verdict
//   all_done           every channel has a verdict
//   cycle              saturating cycle count since reset release
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned     NCH         = 1,
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     TIMEOUT     = 5000,
  parameter int unsigned     CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h0000_1000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           wb_valid,
  input  logic [NCH*REG_IDX_W-1:0] wb_rd,
  input  logic [NCH*XLEN-1:0]      wb_data,
  input  logic [NCH-1:0]           ecall_valid,
`ifdef TEST_MONITOR_TOHOST_EN
  input  logic [NCH-1:0]           st_valid,
  input  logic [NCH*XLEN-1:0]      st_addr,
  input  logic [NCH*XLEN-1:0]      st_data,
`endif
  output logic [NCH-1:0]           done,
  output logic [NCH-1:0]           pass,
  output logic [NCH-1:0]           timeout,
  output logic [NCH*XLEN-1:0]      fail_num,
  output logic [NCH*CNT_W-1:0]     verdict_cycle,
  output logic                     all_done,
  output logic [CNT_W-1:0]         cycle
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  // Elaboration sanity checks on the configuration.
  if (TIMEOUT == 0 || (CNT_W < 32 && 64'(TIMEOUT) >= (64'd1 << CNT_W))) begin : g_bad_timeout
    $error("test_monitor: TIMEOUT must be nonzero and fit in CNT_W");
  end
  if (TOHOST_ADDR[1:0] != 2'b00) begin : g_bad_tohost
    $error("test_monitor: TOHOST_ADDR must be word aligned");
  end

  logic             timeout_hit_c;
  logic [NCH-1:0]   done_nxt_c;

  // Shared cycle counter; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle <= '0;
    end else if (cycle != CNT_MAX) begin
      cycle <= cycle + CNT_W'(1);
    end
  end

  assign timeout_hit_c = (cycle == TO_LAST);

  // Registered from next-state done so it rises with the last channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      all_done <= 1'b0;
    end else begin
      all_done <= &done_nxt_c;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    test_monitor_chan #(
      .XLEN  (XLEN),
      .CNT_W (CNT_W)
`ifdef TEST_MONITOR_TOHOST_EN
      ,
      .TOHOST_ADDR (TOHOST_ADDR)
`endif
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .wb_valid      (wb_valid[c]),
      .wb_rd         (wb_rd[c*REG_IDX_W +: REG_IDX_W]),
      .wb_data       (wb_data[c*XLEN +: XLEN]),
      .ecall_valid   (ecall_valid[c]),
`ifdef TEST_MONITOR_TOHOST_EN
      .st_valid      (st_valid[c]),
      .st_addr       (st_addr[c*XLEN +: XLEN]),
      .st_data       (st_data[c*XLEN +: XLEN]),
`endif
      .timeout_hit   (timeout_hit_c),
      .cycle         (cycle),
      .done_c        (done_nxt_c[c]),
      .done          (done[c]),
      .pass          (pass[c]),
      .timeout       (timeout[c]),
      .fail_num      (fail_num[c*XLEN +: XLEN]),
      .verdict_cycle (verdict_cycle[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor with two channels and a short watchdog.
module tb_test_monitor;

  localparam int unsigned NCH     = 2;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 100;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NCH-1:0]        wb_valid;
  logic [NCH*5-1:0]      wb_rd;
  logic [NCH*XLEN-1:0]   wb_data;
  logic [NCH-1:0]        ecall_valid;
`ifdef TEST_MONITOR_TOHOST_EN
  logic [NCH-1:0]        st_valid;
  logic [NCH*XLEN-1:0]   st_addr;
  logic [NCH*XLEN-1:0]   st_data;
`endif
  logic [NCH-1:0]        done;
  logic [NCH-1:0]        pass;
  logic [NCH-1:0]        timeout;
  logic [NCH*XLEN-1:0]   fail_num;
  logic [NCH*CNT_W-1:0]  verdict_cycle;
  logic                  all_done;
  logic [CNT_W-1:0]      cycle;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  test_monitor #(
    .NCH         (NCH),
    .XLEN        (XLEN),
    .TIMEOUT     (TIMEOUT),
    .CNT_W       (CNT_W),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_valid      (wb_valid),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .ecall_valid   (ecall_valid),
`ifdef TEST_MONITOR_TOHOST_EN
    .st_valid      (st_valid),
    .st_addr       (st_addr),
    .st_data       (st_data),
`endif
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .fail_num      (fail_num),
    .verdict_cycle (verdict_cycle),
    .all_done      (all_done),
    .cycle         (cycle)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_chan(input string tag, input int c, input logic d, input logic p,
                            input logic t, input logic [31:0] fn, input logic [31:0] vc);
    check_eq({tag, ".done"},    64'(done[c]),    64'(d));
    check_eq({tag, ".pass"},    64'(pass[c]),    64'(p));
    check_eq({tag, ".timeout"}, 64'(timeout[c]), 64'(t));
    check_eq({tag, ".fail_num"},      64'(fail_num[c*XLEN +: XLEN]),       64'(fn));
    check_eq({tag, ".verdict_cycle"}, 64'(verdict_cycle[c*CNT_W +: CNT_W]), 64'(vc));
  endtask

  task automatic clear_in();
    wb_valid    = '0;
    wb_rd       = '0;
    wb_data     = '0;
    ecall_valid = '0;
`ifdef TEST_MONITOR_TOHOST_EN
    st_valid    = '0;
    st_addr     = '0;
    st_data     = '0;
`endif
  endtask

  // Inputs set before this call are sampled on the coming edge, whose
  // cycle count is the current value of cyc.
  task automatic next_cyc();
    @(negedge clk);
    cyc++;
    clear_in();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) next_cyc();
  endtask

  task automatic set_wb(input int c, input logic [4:0] rd, input logic [31:0] data);
    wb_valid[c]             = 1'b1;
    wb_rd[c*5 +: 5]         = rd;
    wb_data[c*XLEN +: XLEN] = data;
  endtask

`ifdef TEST_MONITOR_TOHOST_EN
  task automatic set_st(input int c, input logic [31:0] addr, input logic [31:0] data);
    st_valid[c]             = 1'b1;
    st_addr[c*XLEN +: XLEN] = addr;
    st_data[c*XLEN +: XLEN] = data;
  endtask
`endif

  // Drop reset between edges, confirm the asynchronous clear, then release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq({tag, ".rst_done"},     64'(done),          64'd0);
    check_eq({tag, ".rst_timeout"},  64'(timeout),       64'd0);
    check_eq({tag, ".rst_all_done"}, 64'(all_done),      64'd0);
    check_eq({tag, ".rst_cycle"},    64'(cycle),         64'd0);
    check_eq({tag, ".rst_vc"},       64'(verdict_cycle), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    clear_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=stuck exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    clear_in();
    #12;
    check_eq("reset.done",     64'(done),     64'd0);
    check_eq("reset.pass",     64'(pass),     64'd0);
    check_eq("reset.fail_num", 64'(fail_num), 64'd0);
    check_eq("reset.all_done", 64'(all_done), 64'd0);
    check_eq("reset.cycle",    64'(cycle),    64'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;

    // Run 1: ch0 passes at cycle 20, ch1 idle times out at cycle 99.
    run_to(10);
    set_wb(0, 5'd3, 32'd1);
    next_cyc();
    run_to(12);
    set_wb(0, 5'd4, 32'd9);
    next_cyc();
    set_wb(0, 5'd0, 32'd9);
    next_cyc();
    run_to(20);
    ecall_valid[0] = 1'b1;
    next_cyc();
    check_chan("r1.ch0_pass", 0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd20);
    check_chan("r1.ch1_idle", 1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check_eq("r1.all_done_lo", 64'(all_done), 64'd0);
    check_eq("r1.cycle21", 64'(cycle), 64'd21);
    run_to(99);
    check_eq("r1.ch1_not_yet", 64'(done[1]), 64'd0);
    check_eq("r1.all_done_99", 64'(all_done), 64'd0);
    next_cyc();
    check_chan("r1.ch1_to", 1, 1'b1, 1'b0, 1'b1, 32'd0, 32'd99);
    check_chan("r1.ch0_hold", 0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd20);
    check_eq("r1.all_done", 64'(all_done), 64'd1);

    // Run 2: FAIL is sticky; gp bypass on the ecall cycle.
    do_reset("r2");
    run_to(2);
    set_wb(0, 5'd3, 32'd7);
    next_cyc();
    set_wb(1, 5'd3, 32'd5);
    next_cyc();
    run_to(5);
    ecall_valid[0] = 1'b1;
    next_cyc();
    check_chan("r2.ch0_fail", 0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
    check_eq("r2.ch1_run", 64'(done[1]), 64'd0);
    run_to(8);
    set_wb(0, 5'd3, 32'd1);
    ecall_valid[0] = 1'b1;
    set_wb(1, 5'd3, 32'd1);
    ecall_valid[1] = 1'b1;
    next_cyc();
    check_chan("r2.ch0_frozen", 0, 1'b1, 1'b0, 1'b0, 32'd3, 32'd5);
    check_chan("r2.ch1_bypass", 1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd8);
    check_eq("r2.all_done", 64'(all_done), 64'd1);

    // Run 3: ecall exactly at TIMEOUT-1 beats the watchdog.
    do_reset("r3");
    run_to(50);
    set_wb(0, 5'd3, 32'd1);
    next_cyc();
    run_to(99);
    ecall_valid[0] = 1'b1;
    next_cyc();
    check_chan("r3.ch0_edge", 0, 1'b1, 1'b1, 1'b0, 32'd0, 32'd99);
    check_chan("r3.ch1_to",   1, 1'b1, 1'b0, 1'b1, 32'd0, 32'd99);
    check_eq("r3.all_done", 64'(all_done), 64'd1);

    // Run 4: logical shift of a high gp, and ecall with gp at reset value.
    do_reset("r4");
    run_to(3);
    set_wb(0, 5'd3, 32'h8000_0003);
    next_cyc();
    ecall_valid[0] = 1'b1;
    ecall_valid[1] = 1'b1;
    next_cyc();
    check_chan("r4.ch0_shift", 0, 1'b1, 1'b0, 1'b0, 32'h4000_0001, 32'd4);
    check_chan("r4.ch1_gp0",   1, 1'b1, 1'b0, 1'b0, 32'd0,         32'd4);

`ifdef TEST_MONITOR_TOHOST_EN
    // Run 5: tohost store trigger.
    do_reset("r5");
    run_to(2);
    set_st(0, TOHOST, 32'd0);
    next_cyc();
    set_st(0, 32'h0000_2000, 32'd1);
    next_cyc();
    check_eq("r5.store0_none", 64'(done[0]), 64'd0);
    run_to(5);
    set_st(0, TOHOST, 32'h15);
    set_wb(1, 5'd3, 32'd1);
    next_cyc();
    check_chan("r5.ch0_tohost", 0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd5);
    check_eq("r5.ch1_run", 64'(done[1]), 64'd0);
    set_st(1, TOHOST, 32'h15);
    ecall_valid[1] = 1'b1;
    next_cyc();
    check_chan("r5.ch1_both", 1, 1'b1, 1'b0, 1'b0, 32'd10, 32'd6);
`endif

    // Final: mid-run reset restarts the cycle counter.
    run_to(cyc + 3);
    do_reset("fin");
    check_eq("fin.cycle0", 64'(cycle), 64'd0);
    next_cyc();
    next_cyc();
    next_cyc();
    check_eq("fin.cycle3", 64'(cycle), 64'd3);
    check_eq("fin.done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
